// File: rtl/packet_fifo_writer.sv
// Write-side framing stage for the dual-clock packet FIFO: commits good packets, rewinds bad ones.
// Optional statistics counters are enabled by defining PKT_FIFO_WRITER_STATS_EN.
module packet_fifo_writer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH  = 12,
  parameter int unsigned MAX_PKT_LEN = 1518
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  input  logic                  src_start,
  input  logic                  src_end,
  input  logic                  src_error,
  output logic                  src_ready,
  input  logic                  fifo_full,
  input  logic [FIFO_DEPTH-1:0] fifo_address,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_enable,
  output logic                  fifo_start,
  output logic                  fifo_end,
  output logic                  fifo_reset,
  output logic [FIFO_DEPTH-1:0] fifo_reset_address
`ifdef PKT_FIFO_WRITER_STATS_EN
  ,
  output logic [15:0]           pkt_accepted_count,
  output logic [15:0]           pkt_dropped_count
`endif
);

  localparam int unsigned LEN_W = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, PASS, REWIND, DROP} state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [FIFO_DEPTH-1:0] pkt_start_addr_q, pkt_start_addr_d;
  logic                  drop_rest_q, drop_rest_d;
  logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic                  fifo_enable_q, fifo_enable_d;
  logic                  fifo_start_q, fifo_start_d;
  logic                  fifo_end_q, fifo_end_d;
  logic                  fifo_reset_q, fifo_reset_d;
  logic [FIFO_DEPTH-1:0] fifo_reset_address_q, fifo_reset_address_d;
  logic                  accept;
  logic                  abort;
  logic                  acc_inc;
  logic                  drop_inc;

  // Ready depends on the live full flag so back-pressure takes effect in the same cycle
  always_comb begin
    src_ready = 1'b0;
    case (state_q)
      IDLE, PASS: src_ready = !fifo_full;
      DROP:       src_ready = 1'b1;
      default:    src_ready = 1'b0;
    endcase
    if (reset) src_ready = 1'b0;
  end

  always_comb begin
    state_d              = state_q;
    len_d                = len_q;
    drop_rest_d          = drop_rest_q;
    fifo_data_d          = fifo_data_q;
    fifo_start_d         = fifo_start_q;
    fifo_end_d           = fifo_end_q;
    fifo_enable_d        = 1'b0;
    fifo_reset_d         = 1'b0;
    fifo_reset_address_d = fifo_reset_address_q;
    acc_inc              = 1'b0;
    drop_inc             = 1'b0;
    accept               = src_valid && src_ready;
    abort                = src_error || src_start || (len_q == LEN_W'(MAX_PKT_LEN));
    // Start-beat address is visible on fifo_address while its write strobe is out
    pkt_start_addr_d     = (fifo_enable_q && fifo_start_q) ? fifo_address : pkt_start_addr_q;

    case (state_q)
      IDLE: begin
        if (accept && src_start) begin
          if (!src_error) begin
            fifo_enable_d = 1'b1;
            fifo_data_d   = src_data;
            fifo_start_d  = 1'b1;
            fifo_end_d    = src_end;
            len_d         = LEN_W'(1);
            acc_inc       = src_end;
            state_d       = src_end ? IDLE : PASS;
          end else begin
            drop_inc = 1'b1;
            state_d  = src_end ? IDLE : DROP;
          end
        end
      end
      PASS: begin
        if (accept) begin
          if (abort) begin
            // Strobe is registered, so raising it here lands it in the REWIND cycle
            fifo_reset_d         = 1'b1;
            fifo_reset_address_d = pkt_start_addr_d;
            drop_rest_d          = !src_end;
            drop_inc             = 1'b1;
            state_d              = REWIND;
          end else begin
            fifo_enable_d = 1'b1;
            fifo_data_d   = src_data;
            fifo_start_d  = 1'b0;
            fifo_end_d    = src_end;
            len_d         = len_q + LEN_W'(1);
            acc_inc       = src_end;
            state_d       = src_end ? IDLE : PASS;
          end
        end
      end
      REWIND: begin
        state_d = drop_rest_q ? DROP : IDLE;
      end
      DROP: begin
        if (accept && src_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q              <= IDLE;
      len_q                <= '0;
      pkt_start_addr_q     <= '0;
      drop_rest_q          <= 1'b0;
      fifo_data_q          <= '0;
      fifo_enable_q        <= 1'b0;
      fifo_start_q         <= 1'b0;
      fifo_end_q           <= 1'b0;
      fifo_reset_q         <= 1'b0;
      fifo_reset_address_q <= '0;
    end else begin
      state_q              <= state_d;
      len_q                <= len_d;
      pkt_start_addr_q     <= pkt_start_addr_d;
      drop_rest_q          <= drop_rest_d;
      fifo_data_q          <= fifo_data_d;
      fifo_enable_q        <= fifo_enable_d;
      fifo_start_q         <= fifo_start_d;
      fifo_end_q           <= fifo_end_d;
      fifo_reset_q         <= fifo_reset_d;
      fifo_reset_address_q <= fifo_reset_address_d;
    end
  end

  assign fifo_data          = fifo_data_q;
  assign fifo_enable        = fifo_enable_q;
  assign fifo_start         = fifo_start_q;
  assign fifo_end           = fifo_end_q;
  assign fifo_reset         = fifo_reset_q;
  assign fifo_reset_address = fifo_reset_address_q;

`ifdef PKT_FIFO_WRITER_STATS_EN
  logic [15:0] acc_cnt_q, acc_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating packet counters
  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (acc_inc && (acc_cnt_q != 16'hFFFF))   acc_cnt_d  = acc_cnt_q + 16'd1;
    if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_accepted_count = acc_cnt_q;
  assign pkt_dropped_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_packet_fifo_writer.sv
// Scoreboard bench for packet_fifo_writer; a small FIFO address model tracks writes and rewinds.
module tb_packet_fifo_writer;

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 12;
  localparam int unsigned MAXL = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] src_data = '0;
  logic          src_valid = 1'b0;
  logic          src_start = 1'b0;
  logic          src_end = 1'b0;
  logic          src_error = 1'b0;
  logic          src_ready;
  logic          fifo_full = 1'b0;
  logic [AW-1:0] fifo_address;
  logic [DW-1:0] fifo_data;
  logic          fifo_enable;
  logic          fifo_start;
  logic          fifo_end;
  logic          fifo_reset;
  logic [AW-1:0] fifo_reset_address;
`ifdef PKT_FIFO_WRITER_STATS_EN
  logic [15:0]   pkt_accepted_count;
  logic [15:0]   pkt_dropped_count;
`endif

  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_val = '0;

  int errors = 0;
  int checks = 0;

  logic [DW+1:0] wq[$];
  logic [AW-1:0] rq[$];
  logic [DW+1:0] mon_w;
  logic [AW-1:0] mon_r;

  packet_fifo_writer #(.DATA_WIDTH(DW), .FIFO_DEPTH(AW), .MAX_PKT_LEN(MAXL)) dut (
    .clock(clock), .reset(reset),
    .src_data(src_data), .src_valid(src_valid), .src_start(src_start),
    .src_end(src_end), .src_error(src_error), .src_ready(src_ready),
    .fifo_full(fifo_full), .fifo_address(fifo_address),
    .fifo_data(fifo_data), .fifo_enable(fifo_enable), .fifo_start(fifo_start),
    .fifo_end(fifo_end), .fifo_reset(fifo_reset), .fifo_reset_address(fifo_reset_address)
`ifdef PKT_FIFO_WRITER_STATS_EN
    , .pkt_accepted_count(pkt_accepted_count), .pkt_dropped_count(pkt_dropped_count)
`endif
  );

  always #5 clock = ~clock;

  // FIFO write pointer: advances per write, jumps on rewind
  always @(posedge clock or posedge reset) begin
    if (reset)            fifo_address <= '0;
    else if (ld_en)       fifo_address <= ld_val;
    else if (fifo_reset)  fifo_address <= fifo_reset_address;
    else if (fifo_enable) fifo_address <= fifo_address + AW'(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (fifo_enable || fifo_reset) chk("enable_reset_exclusive", {31'd0, fifo_enable & fifo_reset}, 32'd0);
      if (fifo_enable) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got data %0h start %0b end %0b expected none", fifo_data, fifo_start, fifo_end);
        end else begin
          mon_w = wq.pop_front();
          chk("write_data", 32'(fifo_data), 32'(mon_w[DW+1:2]));
          chk("write_start", 32'(fifo_start), 32'(mon_w[1]));
          chk("write_end", 32'(fifo_end), 32'(mon_w[0]));
        end
      end
      if (fifo_reset) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rewind: got addr %0h expected none", fifo_reset_address);
        end else begin
          mon_r = rq.pop_front();
          chk("rewind_addr", 32'(fifo_reset_address), 32'(mon_r));
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic s, input logic e, input logic err, input logic wr);
    int n;
    n = 0;
    if (wr) wq.push_back({d, s, e});
    src_data = d; src_start = s; src_end = e; src_error = err; src_valid = 1'b1;
    #1;
    while (!src_ready && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    if (!src_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got src_ready 0 expected 1 within 50 cycles");
    end
    @(negedge clock);
    src_valid = 1'b0; src_start = 1'b0; src_end = 1'b0; src_error = 1'b0;
  endtask

  task automatic set_addr(input logic [AW-1:0] v);
    ld_val = v; ld_en = 1'b1;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clock);
    chk({name, "_writes_left"}, 32'(wq.size()), 32'd0);
    chk({name, "_rewinds_left"}, 32'(rq.size()), 32'd0);
    wq.delete(); rq.delete();
  endtask

  initial begin
    #1;
    chk("reset_ready", 32'(src_ready), 32'd0);
    chk("reset_fifo_outs", {23'd0, fifo_enable, fifo_start, fifo_end, fifo_reset, fifo_data[4:0]}, 32'd0);
    chk("reset_addr", 32'(fifo_reset_address), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // 1: clean 4-beat packet
    send(8'hA0, 1, 0, 0, 1);
    send(8'hA1, 0, 0, 0, 1);
    send(8'hA2, 0, 0, 0, 1);
    send(8'hA3, 0, 1, 0, 1);
    drain("t1");

    // 2: error on beat 3, rewind to 0x010, drop to end, then normal traffic
    set_addr(12'h010);
    send(8'hB0, 1, 0, 0, 1);
    send(8'hB1, 0, 0, 0, 1);
    rq.push_back(12'h010);
    send(8'hB2, 0, 0, 1, 0);
    chk("rewind_ready", 32'(src_ready), 32'd0);
    chk("rewind_strobe", 32'(fifo_reset), 32'd1);
    @(negedge clock);
    fifo_full = 1'b1;
    #1;
    chk("drop_ready_when_full", 32'(src_ready), 32'd1);
    send(8'hB3, 1, 0, 0, 0);
    fifo_full = 1'b0;
    send(8'hB4, 0, 1, 0, 0);
    send(8'hC0, 1, 1, 0, 1);
    send(8'hC1, 0, 0, 0, 0);
    send(8'hC2, 1, 0, 0, 1);
    send(8'hC3, 0, 1, 0, 1);
    drain("t2");

    // 3: over-length packet aborts on beat MAXL+1
    set_addr(12'h100);
    send(8'h30, 1, 0, 0, 1);
    send(8'h31, 0, 0, 0, 1);
    send(8'h32, 0, 0, 0, 1);
    send(8'h33, 0, 0, 0, 1);
    rq.push_back(12'h100);
    send(8'h34, 0, 0, 0, 0);
    send(8'h35, 0, 1, 0, 0);
    send(8'h36, 1, 1, 0, 1);
    drain("t3");

    // 4: three cycles of back-pressure mid-packet
    send(8'hD0, 1, 0, 0, 1);
    send(8'hD1, 0, 0, 0, 1);
    wq.push_back({8'hD2, 1'b0, 1'b0});
    fifo_full = 1'b1;
    src_data = 8'hD2; src_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("full_ready", 32'(src_ready), 32'd0);
      @(negedge clock); #1;
    end
    chk("full_no_write", 32'(wq.size()), 32'd1);
    fifo_full = 1'b0;
    #1;
    chk("unfull_ready", 32'(src_ready), 32'd1);
    @(negedge clock);
    src_valid = 1'b0;
    send(8'hD3, 0, 1, 0, 1);
    drain("t4");

    // 5: rewind across address wrap, then a single-beat bad packet
    set_addr(12'hFFE);
    send(8'h50, 1, 0, 0, 1);
    send(8'h51, 0, 0, 0, 1);
    send(8'h52, 0, 0, 0, 1);
    rq.push_back(12'hFFE);
    send(8'h53, 0, 1, 1, 0);
    send(8'h54, 1, 1, 1, 0);
    send(8'h55, 1, 1, 0, 1);
    drain("t5");
`ifdef PKT_FIFO_WRITER_STATS_EN
    chk("accepted_count", 32'(pkt_accepted_count), 32'd6);
    chk("dropped_count", 32'(pkt_dropped_count), 32'd4);
`endif

    // 6: asynchronous reset mid-packet
    send(8'hE0, 1, 0, 0, 1);
    send(8'hE1, 0, 0, 0, 1);
    src_data = 8'hE2; src_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("midreset_ready", 32'(src_ready), 32'd0);
    chk("midreset_fifo_outs", {22'd0, fifo_enable, fifo_start, fifo_end, fifo_reset, fifo_data[5:0]}, 32'd0);
    chk("midreset_data", 32'(fifo_data), 32'd0);
    chk("midreset_addr", 32'(fifo_reset_address), 32'd0);
`ifdef PKT_FIFO_WRITER_STATS_EN
    chk("midreset_accepted", 32'(pkt_accepted_count), 32'd0);
    chk("midreset_dropped", 32'(pkt_dropped_count), 32'd0);
`endif
    src_valid = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    send(8'hE2, 0, 0, 0, 0);
    send(8'hF0, 1, 1, 0, 1);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
